// File: rtl/girlanda_pkg.sv
// Shared types and default timing constants for the garland button path.
package girlanda_pkg;

  localparam int MODE_W = 2;

  // Defaults shared with the garland core so both sides agree on timing.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int DEFAULT_LONG_CYCLES     = 100;
  localparam int DEFAULT_REPEAT_CYCLES   = 50;

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    LONG_HELD,
    DEB_RELEASE
  } btn_state_t;

endpackage

// File: rtl/girlanda_button_ctrl_if.sv
// Button-side bundle: raw pin in, conditioned level, event pulses and mode out.
interface girlanda_button_ctrl_if;

  logic                              button_raw;
  logic                              button_clean;
  logic                              pressed;
  logic                              press_p;
  logic                              short_p;
  logic                              long_p;
  logic [girlanda_pkg::MODE_W-1:0]   mode;

  modport master (
    output button_raw,
    input  button_clean, pressed, press_p, short_p, long_p, mode
  );

  modport slave (
    input  button_raw,
    output button_clean, pressed, press_p, short_p, long_p, mode
  );

endinterface

// File: rtl/girlanda_sync2.sv
// Two-flop synchroniser for the asynchronous button pin; resets to the idle level 1.
module girlanda_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/girlanda_button_ctrl.sv
// Debounces the active-low garland button and classifies presses as short or long.
// Define GIRLANDA_AUTO_REPEAT_EN to make long_p repeat every REPEAT_CYCLES while held.
module girlanda_button_ctrl
  import girlanda_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
  input logic                   clk,
  input logic                   reset,
  girlanda_button_ctrl_if.slave btn
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_chk_debounce
    $error("girlanda_button_ctrl: DEBOUNCE_CYCLES must be >= 1");
  end
  if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_chk_long
    $error("girlanda_button_ctrl: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
  end
  if (REPEAT_CYCLES < 1) begin : g_chk_repeat
    $error("girlanda_button_ctrl: REPEAT_CYCLES must be >= 1");
  end

  logic                s;
  btn_state_t          state, state_nxt;
  logic [DEB_W-1:0]    deb_cnt, deb_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic                was_long, was_long_nxt;
  logic                rep_pulse;
  logic                press_nxt, short_nxt, long_nxt, pressed_nxt;
  logic [MODE_W-1:0]   mode_q, mode_nxt;
  logic                press_q, short_q, long_q, pressed_q, clean_q;

  girlanda_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn.button_raw),
    .q     (s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      deb_cnt  <= '0;
      hold_cnt <= '0;
      was_long <= 1'b0;
      mode_q   <= '0;
      press_q  <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      pressed_q <= 1'b0;
      clean_q  <= 1'b1;
    end else begin
      state    <= state_nxt;
      deb_cnt  <= deb_nxt;
      hold_cnt <= hold_nxt;
      was_long <= was_long_nxt;
      mode_q   <= mode_nxt;
      press_q  <= press_nxt;
      short_q  <= short_nxt;
      long_q   <= long_nxt;
      pressed_q <= pressed_nxt;
      clean_q  <= ~pressed_nxt;
    end
  end

  // The first sample of a new level is counted on the transition itself, so
  // deb_cnt == DEBOUNCE_CYCLES with the level still held completes the debounce.
  always_comb begin
    state_nxt    = state;
    deb_nxt      = deb_cnt;
    hold_nxt     = hold_cnt;
    was_long_nxt = was_long;
    case (state)
      IDLE: begin
        deb_nxt = '0;
        if (!s) begin
          state_nxt = DEB_PRESS;
          deb_nxt   = DEB_W'(1);
        end
      end
      DEB_PRESS: begin
        if (s) begin
          state_nxt = IDLE;
          deb_nxt   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = PRESSED;
          deb_nxt   = '0;
          hold_nxt  = '0;
        end else begin
          deb_nxt = deb_cnt + 1'b1;
        end
      end
      PRESSED: begin
        hold_nxt = hold_cnt + 1'b1;
        if (hold_cnt == HOLD_LAST) begin
          state_nxt    = LONG_HELD;
          was_long_nxt = 1'b1;
        end else if (s) begin
          state_nxt    = DEB_RELEASE;
          was_long_nxt = 1'b0;
          deb_nxt      = DEB_W'(1);
        end
      end
      LONG_HELD: begin
        if (hold_cnt != '1) hold_nxt = hold_cnt + 1'b1;
        if (s) begin
          state_nxt    = DEB_RELEASE;
          was_long_nxt = 1'b1;
          deb_nxt      = DEB_W'(1);
        end
      end
      DEB_RELEASE: begin
        if (!s) begin
          state_nxt = was_long ? LONG_HELD : PRESSED;
          deb_nxt   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = IDLE;
          deb_nxt   = '0;
        end else begin
          deb_nxt = deb_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        deb_nxt   = '0;
      end
    endcase
  end

`ifdef GIRLANDA_AUTO_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_cnt;

  // Phase advances only in LONG_HELD, so a release bounce freezes it in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt <= '0;
    end else if (state == PRESSED) begin
      rep_cnt <= '0;
    end else if (state == LONG_HELD) begin
      rep_cnt <= (rep_cnt == REP_LAST) ? '0 : rep_cnt + 1'b1;
    end
  end

  assign rep_pulse = (state == LONG_HELD) && (rep_cnt == REP_LAST);
`else
  assign rep_pulse = 1'b0;
`endif

  // Pulses are decoded from the transition being taken and registered next edge.
  always_comb begin
    press_nxt   = (state == DEB_PRESS) && (state_nxt == PRESSED);
    short_nxt   = (state == DEB_RELEASE) && (state_nxt == IDLE) && !was_long;
    long_nxt    = ((state == PRESSED) && (state_nxt == LONG_HELD)) || rep_pulse;
    pressed_nxt = (state_nxt == PRESSED) || (state_nxt == LONG_HELD) ||
                  (state_nxt == DEB_RELEASE);
    mode_nxt    = mode_q;
    if (short_nxt || rep_pulse) mode_nxt = mode_q + 1'b1;
  end

  assign btn.button_clean = clean_q;
  assign btn.pressed      = pressed_q;
  assign btn.press_p      = press_q;
  assign btn.short_p      = short_q;
  assign btn.long_p       = long_q;
  assign btn.mode         = mode_q;

endmodule

// File: tb/tb_girlanda_button_ctrl.sv
// Scoreboard bench for girlanda_button_ctrl: directed scenarios plus random button waveforms.
// Follows GIRLANDA_AUTO_REPEAT_EN when it is defined for the build.
module tb_girlanda_button_ctrl;

  localparam int DEB = 16;
  localparam int LNG = 100;
  localparam int REP = 50;

  typedef struct {
    int         cyc;
    logic [2:0] kind;
  } ev_t;

  logic clk = 1'b1;
  logic reset;

  girlanda_button_ctrl_if btn ();

  girlanda_button_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LNG),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn   (btn)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   edge_cyc = 0;
  ev_t  expq[$];

  int   n_press = 0, n_short = 0, n_long = 0;
  int   last_press_cyc = -1, last_short_cyc = -1, first_long_cyc = -1;

  bit   d1 = 1'b1, d2 = 1'b1, m_down = 1'b0, m_long = 1'b0;
  int   m_run = 0, m_held = 0, m_rep = 0, m_mode = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input bit level, input int cycles);
    @(negedge clk);
    btn.button_raw = level;
    edge_cyc = cyc + 1;
    repeat (cycles - 1) @(negedge clk);
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference model: a level is accepted after 17 consecutive equal samples
  // (one to notice it, DEB more to confirm); long fires on the 100th cycle
  // spent pressed without a pending release.
  always @(posedge clk) begin
    bit         s;
    logic [2:0] ev;
    cyc++;
    ev = 3'b000;
    if (reset) begin
      d1 = 1'b1; d2 = 1'b1;
      m_down = 1'b0; m_long = 1'b0;
      m_run = 0; m_held = 0; m_rep = 0; m_mode = 0;
    end else begin
      s  = d2;
      d2 = d1;
      d1 = btn.button_raw;
      if (!m_down) begin
        if (s) m_run = 0;
        else if (m_run == DEB) begin
          m_down = 1'b1; m_long = 1'b0; m_run = 0; m_held = 0;
          ev = 3'b100;
        end else m_run++;
      end else if (m_run > 0) begin
        if (!s) m_run = 0;
        else if (m_run == DEB) begin
          m_down = 1'b0; m_run = 0;
          if (!m_long) begin
            ev = 3'b010;
            m_mode = (m_mode + 1) % 4;
          end
        end else m_run++;
      end else if (!m_long) begin
        if (m_held == LNG - 1) begin
          m_long = 1'b1; m_rep = 0;
          ev = 3'b001;
        end else begin
          m_held++;
          if (s) m_run = 1;
        end
      end else begin
`ifdef GIRLANDA_AUTO_REPEAT_EN
        if (m_rep == REP - 1) begin
          m_rep = 0;
          ev = 3'b001;
          m_mode = (m_mode + 1) % 4;
        end else m_rep++;
`endif
        if (s) m_run = 1;
      end
    end
    if (ev != 3'b000) expq.push_back('{cyc, ev});
  end

  logic [2:0] exp_ev, dut_ev;
  ev_t        e;

  // Monitor: pops the scoreboard whenever a pulse is expected or seen.
  always @(posedge clk) begin
    #1;
    exp_ev = 3'b000;
    if (expq.size() > 0 && expq[0].cyc == cyc) begin
      e = expq.pop_front();
      exp_ev = e.kind;
    end
    dut_ev = {btn.press_p, btn.short_p, btn.long_p};
    if (dut_ev != 3'b000 || exp_ev != 3'b000)
      checkOutput("pulse_vector", int'(dut_ev), int'(exp_ev));
    if ($countones(dut_ev) > 1)
      checkOutput("one_pulse_at_a_time", $countones(dut_ev), 1);
    checkOutput("pressed_level", int'(btn.pressed), int'(m_down));
    checkOutput("button_clean_level", int'(btn.button_clean), int'(!m_down));
    checkOutput("mode_value", int'(btn.mode), m_mode);
    if (btn.press_p) begin
      n_press++; last_press_cyc = cyc; first_long_cyc = -1;
    end
    if (btn.short_p) begin
      n_short++; last_short_cyc = cyc;
    end
    if (btn.long_p) begin
      n_long++;
      if (first_long_cyc < 0) first_long_cyc = cyc;
    end
  end

  initial begin
    int fall, rise, np, ns, nl, mb, lo, hi;
    btn.button_raw = 1'b1;
    reset = 1'b1;
    #2;
    checkOutput("reset_button_clean", int'(btn.button_clean), 1);
    checkOutput("reset_pressed", int'(btn.pressed), 0);
    checkOutput("reset_pulses", int'({btn.press_p, btn.short_p, btn.long_p}), 0);
    checkOutput("reset_mode", int'(btn.mode), 0);
    #13;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("idle_no_pulses", n_press + n_short + n_long, 0);

    $display("[TB] short press");
    applyStimulus(1'b0, 25);
    fall = edge_cyc;
    applyStimulus(1'b1, 40);
    rise = edge_cyc;
    checkOutput("press_latency", last_press_cyc - fall, 18);
    checkOutput("short_latency", last_short_cyc - rise, 18);
    checkOutput("mode_after_short", int'(btn.mode), 1);
    checkOutput("no_long_on_short", n_long, 0);

    $display("[TB] glitch rejection");
    np = n_press;
    applyStimulus(1'b0, 10);
    applyStimulus(1'b1, 30);
    checkOutput("glitch_no_press", n_press - np, 0);
    checkOutput("glitch_pressed", int'(btn.pressed), 0);
    checkOutput("glitch_mode", int'(btn.mode), 1);

    $display("[TB] four short presses");
    resetDut();
    ns = n_short;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 25);
      applyStimulus(1'b1, 300);
      checkOutput("mode_sequence", int'(btn.mode), (i + 1) % 4);
      checkOutput("short_count", n_short - ns, i + 1);
    end

    $display("[TB] long hold with bounce");
    ns = n_short; nl = n_long; mb = int'(btn.mode);
    applyStimulus(1'b0, 150);
    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 45);
    checkOutput("pressed_through_bounce", int'(btn.pressed), 1);
    applyStimulus(1'b1, 60);
    checkOutput("long_latency", first_long_cyc - last_press_cyc, 100);
    checkOutput("no_short_after_long", n_short - ns, 0);
`ifdef GIRLANDA_AUTO_REPEAT_EN
    checkOutput("long_repeats", int'((n_long - nl) > 1), 1);
`else
    checkOutput("long_once", n_long - nl, 1);
    checkOutput("mode_kept_after_long", int'(btn.mode), mb);
`endif

    $display("[TB] reset mid-press");
    np = n_press; ns = n_short;
    applyStimulus(1'b0, 10);
    reset = 1'b1;
    #1;
    checkOutput("midreset_pressed", int'(btn.pressed), 0);
    checkOutput("midreset_clean", int'(btn.button_clean), 1);
    checkOutput("midreset_mode", int'(btn.mode), 0);
    checkOutput("midreset_pulses", int'({btn.press_p, btn.short_p, btn.long_p}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (11) @(negedge clk);
    applyStimulus(1'b1, 40);
    checkOutput("midreset_no_press", n_press - np, 0);
    checkOutput("midreset_no_short", n_short - ns, 0);

    $display("[TB] random waveforms");
    for (int i = 0; i < 40; i++) begin
      lo = ($urandom_range(0, 4) == 0) ? int'($urandom_range(100, 130)) : int'($urandom_range(1, 40));
      hi = int'($urandom_range(1, 40));
      applyStimulus(1'b0, lo);
      applyStimulus(1'b1, hi);
    end
    applyStimulus(1'b1, 40);
    checkOutput("scoreboard_drained", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
